pe_mac_stage: RTL and testbench

Output-stationary multiply-accumulate stage of the NPU processing element. It consumes the registered operand pair (a, b) and streams signed products into an accumulator across one dot product. A dot product is delimited by first/last flags. It forwards the operands one cycle later to the neighbouring PE, and presents the finished sum through a valid/ready output buffer.

---
 rtl/npu_pkg.sv | 20 ++
 rtl/regN.sv | 17 +
 rtl/pe_mac_stage.sv | 134 +++++++++++++
 tb/tb_pe_mac_stage.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/npu_pkg.sv
// Shared types and helpers for the NPU processing-element datapath.
package npu_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_ACC_W  = 24;
  localparam int EXT_W      = 64;

  typedef enum logic {
    IDLE = 1'b0,
    ACC  = 1'b1
  } pe_state_t;

  // Sign-extend the low pw bits of p across the full EXT_W word.
  function automatic logic [EXT_W-1:0] sext_prod(input logic [EXT_W-1:0] p, input int pw);
    logic [EXT_W-1:0] m;
    m = {EXT_W{1'b1}} << pw;
    return p[6'(pw - 1)] ? (p | m) : (p & ~m);
  endfunction

endpackage

// File: rtl/regN.sv
// Generic enabled register with synchronous active-high clear.
module regN #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst)     q <= '0;
    else if (en) q <= d;
  end

endmodule

// File: rtl/pe_mac_stage.sv
// Output-stationary MAC stage: product register, accumulator FSM and result buffer.
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   IDLE  | no dot product open; next valid product starts a new sum
//   ACC   | dot product open; products accumulate until a last beat
module pe_mac_stage import npu_pkg::*; #(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ACC_W  = DEF_ACC_W,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_first,
  input  logic              in_last,
  input  logic [DATA_W-1:0] a_in,
  input  logic [DATA_W-1:0] b_in,
  output logic [DATA_W-1:0] a_out,
  output logic [DATA_W-1:0] b_out,
  output logic              fwd_valid,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_data,
  output logic [CNT_W-1:0]  out_count
);

  localparam int PROD_W = 2 * DATA_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  if (ACC_W < PROD_W) begin : g_width_check
    $error("pe_mac_stage: ACC_W must be at least 2*DATA_W");
  end

  logic stall, accept;
  logic signed [PROD_W-1:0] a_ext, b_ext;
  logic [PROD_W-1:0] p1;
  logic v1, first1, last1;
  logic [ACC_W-1:0] p1_acc, acc, acc_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic done;
  pe_state_t state, state_nxt;

  // Everything freezes while a finished result waits for the consumer.
  assign stall    = out_valid & ~out_ready;
  assign in_ready = ~stall;
  assign accept   = in_valid & in_ready;

  assign a_ext  = {{DATA_W{a_in[DATA_W-1]}}, a_in};
  assign b_ext  = {{DATA_W{b_in[DATA_W-1]}}, b_in};
  assign p1_acc = ACC_W'(sext_prod(EXT_W'(p1), PROD_W));

  regN #(.W(DATA_W)) u_a_fwd (.clk(clk), .rst(rst), .en(accept), .d(a_in), .q(a_out));
  regN #(.W(DATA_W)) u_b_fwd (.clk(clk), .rst(rst), .en(accept), .d(b_in), .q(b_out));

  always_ff @(posedge clk) begin
    if (rst) fwd_valid <= 1'b0;
    else     fwd_valid <= accept;
  end

  // S1: product register
  always_ff @(posedge clk) begin
    if (rst) begin
      v1     <= 1'b0;
      p1     <= '0;
      first1 <= 1'b0;
      last1  <= 1'b0;
    end else if (!stall) begin
      v1 <= accept;
      if (accept) begin
        p1     <= a_ext * b_ext;
        first1 <= in_first;
        last1  <= in_last;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst)         state <= IDLE;
    else if (!stall) state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (v1 && !last1) state_nxt = ACC;
      ACC:     if (v1 && last1)  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    acc_nxt = acc;
    cnt_nxt = cnt;
    if (v1) begin
      if (state == IDLE || first1) begin
        acc_nxt = p1_acc;
        cnt_nxt = CNT_W'(1);
      end else begin
        acc_nxt = acc + p1_acc;
        cnt_nxt = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
      end
    end
  end

  // S2: accumulator; done flags a completed sum for the result buffer.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc  <= '0;
      cnt  <= '0;
      done <= 1'b0;
    end else if (!stall) begin
      acc  <= acc_nxt;
      cnt  <= cnt_nxt;
      done <= v1 & last1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_count <= '0;
    end else if (done && !stall) begin
      out_valid <= 1'b1;
      out_data  <= acc;
      out_count <= cnt;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pe_mac_stage.sv
// Directed bench for pe_mac_stage: vector table plus hand-written corner sequences.
module tb_pe_mac_stage;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        in_valid, in_ready, in_first, in_last, fwd_valid, out_valid, out_ready;
  logic [7:0]  a_in, b_in, a_out, b_out, out_count;
  logic [23:0] out_data;

  logic        in_valid2, in_ready2, in_first2, in_last2, fwd_valid2, out_valid2, out_ready2;
  logic [7:0]  a_in2, b_in2, a_out2, b_out2, out_count2;
  logic [15:0] out_data2;

  pe_mac_stage #(.DATA_W(8), .ACC_W(24), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_first(in_first), .in_last(in_last), .a_in(a_in), .b_in(b_in),
    .a_out(a_out), .b_out(b_out), .fwd_valid(fwd_valid),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_count(out_count)
  );

  pe_mac_stage #(.DATA_W(8), .ACC_W(16), .CNT_W(8)) dut16 (
    .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2),
    .in_first(in_first2), .in_last(in_last2), .a_in(a_in2), .b_in(b_in2),
    .a_out(a_out2), .b_out(b_out2), .fwd_valid(fwd_valid2),
    .out_valid(out_valid2), .out_ready(out_ready2),
    .out_data(out_data2), .out_count(out_count2)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic        v, f, l;
    logic [7:0]  a, b;
    logic        r;
    logic [23:0] d;
    logic [7:0]  c;
  } vec_t;

  localparam int N = 21;
  vec_t tbl[N];

  function automatic vec_t mk(input logic v, input logic f, input logic l, input int a,
                              input int b, input logic r, input int d, input int c);
    vec_t t;
    t.v = v; t.f = f; t.l = l; t.a = 8'(a); t.b = 8'(b);
    t.r = r; t.d = 24'(d); t.c = 8'(c);
    return t;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic beat2(input logic f, input logic l, input logic [7:0] a, input logic [7:0] b);
    in_valid2 = 1'b1; in_first2 = f; in_last2 = l; a_in2 = a; b_in2 = b;
    tick();
    in_valid2 = 1'b0; in_first2 = 1'b0; in_last2 = 1'b0;
  endtask

  task automatic wait_res2(input string nm, input logic [15:0] d, input logic [7:0] c);
    int k;
    k = 0;
    while (!out_valid2 && k < 8) begin
      tick();
      k++;
    end
    chk({nm, " valid"}, out_valid2, 1'b1);
    if (out_valid2) begin
      chk({nm, " data"}, out_data2, d);
      chk({nm, " count"}, out_count2, c);
    end
    tick();
  endtask

  initial begin
    logic [7:0] fa, fb;

    tbl[0]  = mk(1, 1, 0,    1,    5, 0,     0, 0);
    tbl[1]  = mk(1, 0, 0,    2,    6, 0,     0, 0);
    tbl[2]  = mk(1, 0, 0,    3,    7, 0,     0, 0);
    tbl[3]  = mk(1, 0, 1,    4,    8, 1,    70, 4);
    tbl[4]  = mk(0, 0, 0,    0,    0, 0,     0, 0);
    tbl[5]  = mk(1, 1, 1, -128, -128, 1, 16384, 1);
    tbl[6]  = mk(1, 1, 1,   -3,    5, 1,   -15, 1);
    tbl[7]  = mk(1, 1, 1,    2,    3, 1,     6, 1);
    tbl[8]  = mk(1, 1, 1,   -1,    1, 1,    -1, 1);
    tbl[9]  = mk(1, 1, 1,   10,   10, 1,   100, 1);
    tbl[10] = mk(1, 1, 0,    1,    1, 0,     0, 0);
    tbl[11] = mk(0, 0, 0,    9,    9, 0,     0, 0);
    tbl[12] = mk(1, 0, 1,    2,    2, 1,     5, 2);
    tbl[13] = mk(1, 1, 0,    7,    7, 0,     0, 0);
    tbl[14] = mk(1, 1, 0,    3,    3, 0,     0, 0);
    tbl[15] = mk(1, 0, 1,    4,    4, 1,    25, 2);
    tbl[16] = mk(1, 0, 0,    5,    5, 0,     0, 0);
    tbl[17] = mk(1, 0, 1,    1,    2, 1,    27, 2);
    tbl[18] = mk(0, 0, 0,    0,    0, 0,     0, 0);
    tbl[19] = mk(0, 0, 0,    0,    0, 0,     0, 0);
    tbl[20] = mk(0, 0, 0,    0,    0, 0,     0, 0);

    rst = 1'b1;
    in_valid = 0; in_first = 0; in_last = 0; a_in = 0; b_in = 0; out_ready = 1;
    in_valid2 = 0; in_first2 = 0; in_last2 = 0; a_in2 = 0; b_in2 = 0; out_ready2 = 1;
    tick();
    tick();
    rst = 1'b0;

    chk("reset out_valid", out_valid, 1'b0);
    chk("reset in_ready", in_ready, 1'b1);
    chk("reset fwd_valid", fwd_valid, 1'b0);
    chk("reset a_out", a_out, 8'd0);
    chk("reset out_data", out_data, 24'd0);
    chk("reset out_count", out_count, 8'd0);

    fa = 8'd0; fb = 8'd0;
    for (int n = 0; n < N; n++) begin
      in_valid = tbl[n].v; in_first = tbl[n].f; in_last = tbl[n].l;
      a_in = tbl[n].a; b_in = tbl[n].b;
      tick();
      if (tbl[n].v) begin
        fa = tbl[n].a;
        fb = tbl[n].b;
      end
      chk($sformatf("vec%0d fwd_valid", n), fwd_valid, tbl[n].v);
      chk($sformatf("vec%0d a_out", n), a_out, fa);
      chk($sformatf("vec%0d b_out", n), b_out, fb);
      if (n >= 2) begin
        chk($sformatf("vec%0d out_valid", n), out_valid, tbl[n-2].r);
        if (tbl[n-2].r) begin
          chk($sformatf("vec%0d out_data", n), out_data, tbl[n-2].d);
          chk($sformatf("vec%0d out_count", n), out_count, tbl[n-2].c);
        end
      end else begin
        chk($sformatf("vec%0d out_valid", n), out_valid, 1'b0);
      end
    end
    in_valid = 0; in_first = 0; in_last = 0;

    // Back-pressure
    out_ready = 0;
    in_valid = 1; in_first = 1; in_last = 1; a_in = 8'd3; b_in = 8'd4;
    tick();
    in_valid = 0; in_first = 0; in_last = 0;
    tick();
    tick();
    chk("bp held valid", out_valid, 1'b1);
    chk("bp held data", out_data, 24'd12);
    chk("bp held count", out_count, 8'd1);
    in_valid = 1; in_first = 1; in_last = 1; a_in = 8'd5; b_in = 8'd6;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("bp in_ready", in_ready, 1'b0);
      chk("bp out_valid", out_valid, 1'b1);
      chk("bp data stable", out_data, 24'd12);
      chk("bp a_out frozen", a_out, 8'd3);
      chk("bp b_out frozen", b_out, 8'd4);
      chk("bp fwd_valid", fwd_valid, 1'b0);
    end
    out_ready = 1;
    #1;
    chk("bp release in_ready", in_ready, 1'b1);
    tick();
    in_valid = 0; in_first = 0; in_last = 0;
    chk("bp accept fwd_valid", fwd_valid, 1'b1);
    chk("bp accept a_out", a_out, 8'd5);
    chk("bp taken out_valid", out_valid, 1'b0);
    tick();
    chk("bp gap out_valid", out_valid, 1'b0);
    tick();
    chk("bp next valid", out_valid, 1'b1);
    chk("bp next data", out_data, 24'd30);
    chk("bp next count", out_count, 8'd1);
    tick();
    chk("bp no duplicate", out_valid, 1'b0);

    // Reset in the middle of a dot product
    in_valid = 1; in_first = 1; in_last = 0; a_in = 8'd1; b_in = 8'd1;
    tick();
    in_first = 0; a_in = 8'd2; b_in = 8'd2;
    tick();
    in_valid = 0;
    rst = 1;
    tick();
    rst = 0;
    chk("midrst out_valid", out_valid, 1'b0);
    chk("midrst out_data", out_data, 24'd0);
    chk("midrst out_count", out_count, 8'd0);
    chk("midrst a_out", a_out, 8'd0);
    chk("midrst b_out", b_out, 8'd0);
    chk("midrst fwd_valid", fwd_valid, 1'b0);
    chk("midrst in_ready", in_ready, 1'b1);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("midrst no result", out_valid, 1'b0);
    end
    in_valid = 1; in_first = 1; in_last = 1; a_in = 8'd2; b_in = 8'd3;
    tick();
    in_valid = 0; in_first = 0; in_last = 0;
    tick();
    tick();
    chk("postrst valid", out_valid, 1'b1);
    chk("postrst data", out_data, 24'd6);
    chk("postrst count", out_count, 8'd1);

    // 16-bit accumulator: wrap-around and count saturation
    beat2(1, 0, 8'd127, 8'd127);
    beat2(0, 0, 8'd127, 8'd127);
    beat2(0, 1, 8'd127, 8'd127);
    wait_res2("wrap3", 16'hBD03, 8'd3);
    for (int i = 0; i < 5; i++) beat2(i == 0, i == 4, 8'd127, 8'd127);
    wait_res2("wrap5", 16'h3B05, 8'd5);
    for (int i = 0; i < 300; i++) beat2(i == 0, i == 299, 8'd1, 8'd1);
    wait_res2("sat300", 16'd300, 8'd255);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
